// File: rtl/fp16_pkg.sv
// Shared binary16 definitions for the multiplier and the downstream adder.
package fp16_pkg;

    localparam int unsigned FP16_BIAS  = 15;
    localparam int unsigned FP16_EXP_W = 5;
    localparam int unsigned FP16_FRA_W = 10;

    localparam logic [4:0]  FP16_EXP_MAX = 5'h1F;
    localparam logic [15:0] FP16_QNAN    = 16'h7E00;

    // Operand class; subnormals are folded into ClsZero (denormals-are-zero).
    typedef enum logic [1:0] {
        ClsZero   = 2'd0,
        ClsNormal = 2'd1,
        ClsInf    = 2'd2,
        ClsNan    = 2'd3
    } fp16_class_e;

endpackage

// File: rtl/fp16_unpack.sv
// Combinational binary16 field split and classification.
module fp16_unpack
    import fp16_pkg::*;
(
    input  logic [15:0]  op,
    output logic         sign,
    output logic [4:0]   exp,
    output logic [10:0]  sig,
    output fp16_class_e  cls
);

    // Split fields, restore hidden bit, and classify the operand.
    always_comb begin
        sign = op[15];
        exp  = op[14:10];
        sig  = (op[14:10] == 5'd0) ? 11'd0 : {1'b1, op[9:0]};
        if (op[14:10] == 5'd0) begin
            cls = ClsZero;
        end else if (op[14:10] == FP16_EXP_MAX) begin
            cls = (op[9:0] == 10'd0) ? ClsInf : ClsNan;
        end else begin
            cls = ClsNormal;
        end
    end

endmodule

// File: rtl/fp16_mult_pipe.sv
// Three-stage binary16 multiplier: flush-to-zero, truncating, no backpressure.
module fp16_mult_pipe
    import fp16_pkg::*;
(
    input  logic         CLK,
    input  logic         Reset,
    input  logic         in_valid,
    input  logic [15:0]  input_a,
    input  logic [15:0]  input_b,
    output logic         out_valid,
    output logic [15:0]  output_z,
    output logic         o_overflow,
    output logic         o_underflow,
    output logic         o_NaN,
    output logic         o_zero
);

    // S1 state
    logic        s1_valid_q;
    logic [15:0] s1_a_q, s1_b_q;

    // S2 state; only the product bits that can reach the mantissa are kept
    logic        s2_valid_q;
    logic        s2_sign_q;
    logic [6:0]  s2_exp_q;
    logic [11:0] s2_prod_q;
    fp16_class_e s2_cls_a_q, s2_cls_b_q;

    // S3 / output state
    logic        out_valid_q;
    logic [15:0] z_q;
    logic        ovf_q, unf_q, nan_q, zero_q;

    // S2 combinational
    logic        sign_a, sign_b;
    logic [4:0]  exp_a, exp_b;
    logic [10:0] sig_a, sig_b;
    fp16_class_e cls_a, cls_b;
    logic [11:0] prod_hi;
    logic [9:0]  prod_lo_unused;
    logic [6:0]  exp_sum;

    fp16_unpack u_unpack_a (
        .op   (s1_a_q),
        .sign (sign_a),
        .exp  (exp_a),
        .sig  (sig_a),
        .cls  (cls_a)
    );

    fp16_unpack u_unpack_b (
        .op   (s1_b_q),
        .sign (sign_b),
        .exp  (exp_b),
        .sig  (sig_b),
        .cls  (cls_b)
    );

    assign {prod_hi, prod_lo_unused} = {11'd0, sig_a} * {11'd0, sig_b};
    // Two's-complement 7-bit result; S3 reads it as signed.
    assign exp_sum = {2'b00, exp_a} + {2'b00, exp_b} - 7'(FP16_BIAS);

    // S3 combinational
    logic signed [6:0] exp_n;
    logic [9:0]        mant;
    logic [15:0]       z_d;
    logic              ovf_d, unf_d, nan_d, zero_d;
    logic              any_nan, any_inf, any_zero;

    // Normalize, resolve special cases in priority order, and pack.
    always_comb begin
        any_inf  = (s2_cls_a_q == ClsInf) || (s2_cls_b_q == ClsInf);
        any_zero = (s2_cls_a_q == ClsZero) || (s2_cls_b_q == ClsZero);
        any_nan  = (s2_cls_a_q == ClsNan) || (s2_cls_b_q == ClsNan) || (any_inf && any_zero);
        if (s2_prod_q[11]) begin
            mant  = s2_prod_q[10:1];
            exp_n = $signed(s2_exp_q) + 7'sd1;
        end else begin
            mant  = s2_prod_q[9:0];
            exp_n = $signed(s2_exp_q);
        end
        z_d    = {s2_sign_q, exp_n[4:0], mant};
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        nan_d  = 1'b0;
        zero_d = 1'b0;
        if (any_nan) begin
            z_d   = FP16_QNAN;
            nan_d = 1'b1;
        end else if (any_inf) begin
            z_d   = {s2_sign_q, FP16_EXP_MAX, 10'd0};
            ovf_d = 1'b1;
        end else if (any_zero) begin
            z_d    = {s2_sign_q, 15'd0};
            zero_d = 1'b1;
        end else if (exp_n >= 7'sd31) begin
            z_d   = {s2_sign_q, FP16_EXP_MAX, 10'd0};
            ovf_d = 1'b1;
        end else if (exp_n <= 7'sd0) begin
            z_d    = {s2_sign_q, 15'd0};
            unf_d  = 1'b1;
            zero_d = 1'b1;
        end
    end

    // Pipeline registers; data loads only alongside a valid so bubbles leave state alone.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_exp_q    <= '0;
            s2_prod_q   <= '0;
            s2_cls_a_q  <= ClsZero;
            s2_cls_b_q  <= ClsZero;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            nan_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            s1_valid_q  <= in_valid;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            if (in_valid) begin
                s1_a_q <= input_a;
                s1_b_q <= input_b;
            end
            if (s1_valid_q) begin
                s2_sign_q  <= sign_a ^ sign_b;
                s2_exp_q   <= exp_sum;
                s2_prod_q  <= prod_hi;
                s2_cls_a_q <= cls_a;
                s2_cls_b_q <= cls_b;
            end
            if (s2_valid_q) begin
                z_q    <= z_d;
                ovf_q  <= ovf_d;
                unf_q  <= unf_d;
                nan_q  <= nan_d;
                zero_q <= zero_d;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign output_z    = z_q;
    assign o_overflow  = ovf_q;
    assign o_underflow = unf_q;
    assign o_NaN       = nan_q;
    assign o_zero      = zero_q;

endmodule
